// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and helpers for the VGA dither output stage.
// Bayer matrix, position bundle, threshold scaling, saturating shift.
package vga_pkg;

   // Widest channel the helpers handle; callers cast results down.
   localparam int unsigned MAX_W = 16;

   typedef struct packed {
      logic [1:0] x;
      logic [1:0] y;
      logic [1:0] f;
   } pos_t;

   // 4x4 ordered-dither matrix, indexed [row][col].
   localparam logic [3:0] B4 [4][4] = '{
      '{4'd0,  4'd8,  4'd2,  4'd10},
      '{4'd12, 4'd4,  4'd14, 4'd6},
      '{4'd3,  4'd11, 4'd1,  4'd9},
      '{4'd15, 4'd7,  4'd13, 4'd5}
   };

   // Level a sync line rests at when not asserted.
   function automatic logic sync_idle(input bit active_low);
      return active_low;
   endfunction

   // Stretch or shrink the 4-bit Bayer value so it stays below 2^d.
   function automatic logic [MAX_W-1:0] scale_threshold(
      input logic [3:0]  b,
      input int unsigned d
   );
      logic [MAX_W-1:0] w;
      w = {{(MAX_W-4){1'b0}}, b};
      if (d == 0) return '0;
      if (d >= 4) return w << (d - 4);
      return w >> (4 - d);
   endfunction

   // Drop d LSBs, clamp to the largest out_w-bit code.
   function automatic logic [MAX_W-1:0] sat_shift(
      input logic [MAX_W:0] s,
      input int unsigned    d,
      input int unsigned    out_w
   );
      logic [MAX_W:0] one;
      logic [MAX_W:0] mx;
      logic [MAX_W:0] r;
      one = {{MAX_W{1'b0}}, 1'b1};
      mx  = (one << out_w) - one;
      r   = s >> d;
      if (r > mx) r = mx;
      return r[MAX_W-1:0];
   endfunction

endpackage

// File: rtl/vga_dither_chan.sv
// vga_dither_chan: stage-2 add, shift and clamp for one colour channel.
// Ports: clk, rst_n, pix (stage-1 colour), thr (stage-1 threshold), out.
module vga_dither_chan
   import vga_pkg::*;
#(
   parameter int unsigned IN_W  = 8,
   parameter int unsigned OUT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IN_W-1:0]  pix,
   input  logic [IN_W-1:0]  thr,
   output logic [OUT_W-1:0] out
);

   localparam int unsigned D = IN_W - OUT_W;

   logic [OUT_W-1:0] out_d;
   logic [OUT_W-1:0] out_q;

   // One extra bit keeps the carry so full-scale plus threshold clamps.
   always_comb begin
      out_d = OUT_W'(sat_shift(
         (MAX_W+1)'({1'b0, pix} + {1'b0, thr}), D, OUT_W));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: rtl/vga_dither_out.sv
// vga_dither_out: 2-cycle VGA colour reducer with 4x4 ordered dithering.
// Ports: CLK_25MHZ, RESET_N, DITHER_ON, IN_* sync/colour in, VGA_* out, FRAME_TICK.
module vga_dither_out
   import vga_pkg::*;
#(
   parameter int unsigned IN_W            = 8,
   parameter int unsigned OUT_W           = 4,
   parameter bit          SYNC_ACTIVE_LOW = 1'b1,
   parameter bit          TEMPORAL_EN     = 1'b1
) (
   input  logic             CLK_25MHZ,
   input  logic             RESET_N,
   input  logic             DITHER_ON,
   input  logic             IN_HSYNC,
   input  logic             IN_VSYNC,
   input  logic [IN_W-1:0]  IN_RED,
   input  logic [IN_W-1:0]  IN_GREEN,
   input  logic [IN_W-1:0]  IN_BLUE,
   output logic             VGA_HSYNC,
   output logic             VGA_VSYNC,
   output logic [OUT_W-1:0] VGA_RED,
   output logic [OUT_W-1:0] VGA_GREEN,
   output logic [OUT_W-1:0] VGA_BLUE,
   output logic             FRAME_TICK
);

   localparam int unsigned D    = IN_W - OUT_W;
   localparam logic        IDLE = sync_idle(SYNC_ACTIVE_LOW);

   // stage 1
   logic            hs1_q, hs1_d;
   logic            vs1_q, vs1_d;
   logic            hsp_q, hsp_d;
   logic            vsp_q, vsp_d;
   logic [IN_W-1:0] red1_q, red1_d;
   logic [IN_W-1:0] grn1_q, grn1_d;
   logic [IN_W-1:0] blu1_q, blu1_d;
   logic [IN_W-1:0] thr1_q, thr1_d;

   // position / frame state
   pos_t pos_q, pos_d;
   logic act_q, act_d;

   // stage 2
   logic hs2_q, hs2_d;
   logic vs2_q, vs2_d;
   logic tick_q, tick_d;

   logic       hs_edge;
   logic       vs_edge;
   logic [1:0] xi;
   logic [1:0] yi;

   always_comb begin
      hs1_d  = IN_HSYNC;
      vs1_d  = IN_VSYNC;
      hsp_d  = hs1_q;
      vsp_d  = vs1_q;
      red1_d = IN_RED;
      grn1_d = IN_GREEN;
      blu1_d = IN_BLUE;

      hs_edge = (hs1_q != IDLE) && (hsp_q == IDLE);
      vs_edge = (vs1_q != IDLE) && (vsp_q == IDLE);

      pos_d = pos_q;
      act_d = act_q;
      pos_d.x = hs_edge ? 2'd0 : pos_q.x + 2'd1;
      if (hs_edge) pos_d.y = pos_q.y + 2'd1;
      // VS after HS so a shared edge leaves y cleared.
      if (vs_edge) begin
         pos_d.y = 2'd0;
         pos_d.f = TEMPORAL_EN ? pos_q.f + 2'd1 : 2'd0;
         act_d   = DITHER_ON;
      end

      // Index follows the updated counters so the pixel entering
      // stage 1 alongside an edge already sees the new line/frame.
      xi = pos_d.x + pos_d.f;
      yi = pos_d.y + pos_d.f;
      thr1_d = IN_W'(scale_threshold(B4[yi][xi], D));
      if (!act_d) thr1_d = '0;

      hs2_d  = hs1_q;
      vs2_d  = vs1_q;
      tick_d = vs_edge;
   end

   always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
      if (!RESET_N) begin
         hs1_q  <= IDLE;
         vs1_q  <= IDLE;
         hsp_q  <= IDLE;
         vsp_q  <= IDLE;
         red1_q <= '0;
         grn1_q <= '0;
         blu1_q <= '0;
         thr1_q <= '0;
         pos_q  <= '0;
         act_q  <= 1'b0;
         hs2_q  <= IDLE;
         vs2_q  <= IDLE;
         tick_q <= 1'b0;
      end else begin
         hs1_q  <= hs1_d;
         vs1_q  <= vs1_d;
         hsp_q  <= hsp_d;
         vsp_q  <= vsp_d;
         red1_q <= red1_d;
         grn1_q <= grn1_d;
         blu1_q <= blu1_d;
         thr1_q <= thr1_d;
         pos_q  <= pos_d;
         act_q  <= act_d;
         hs2_q  <= hs2_d;
         vs2_q  <= vs2_d;
         tick_q <= tick_d;
      end
   end

   vga_dither_chan #(.IN_W(IN_W), .OUT_W(OUT_W)) u_red (
      .clk   (CLK_25MHZ),
      .rst_n (RESET_N),
      .pix   (red1_q),
      .thr   (thr1_q),
      .out   (VGA_RED)
   );

   vga_dither_chan #(.IN_W(IN_W), .OUT_W(OUT_W)) u_grn (
      .clk   (CLK_25MHZ),
      .rst_n (RESET_N),
      .pix   (grn1_q),
      .thr   (thr1_q),
      .out   (VGA_GREEN)
   );

   vga_dither_chan #(.IN_W(IN_W), .OUT_W(OUT_W)) u_blu (
      .clk   (CLK_25MHZ),
      .rst_n (RESET_N),
      .pix   (blu1_q),
      .thr   (thr1_q),
      .out   (VGA_BLUE)
   );

   assign VGA_HSYNC  = hs2_q;
   assign VGA_VSYNC  = vs2_q;
   assign FRAME_TICK = tick_q;

endmodule

// File: tb/tb_vga_dither_out.sv
// tb_vga_dither_out: scoreboard bench for 4-, 8- and 6-bit output instances.
// Stimulus pushes expected pixels; a monitor pops and compares each cycle.
module tb_vga_dither_out;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       don;
   logic       ihs, ivs;
   logic [7:0] ir, ig, ib;

   logic       hs_4, vs_4, tk_4;
   logic [3:0] r_4, g_4, b_4;
   logic       hs_0, vs_0, tk_0;
   logic [7:0] r_0, g_0, b_0;
   logic       hs_2, vs_2, tk_2;
   logic [5:0] r_2, g_2, b_2;

   always #20 clk = ~clk;

   vga_dither_out u_d4 (
      .CLK_25MHZ (clk), .RESET_N (rst_n), .DITHER_ON (don),
      .IN_HSYNC (ihs), .IN_VSYNC (ivs),
      .IN_RED (ir), .IN_GREEN (ig), .IN_BLUE (ib),
      .VGA_HSYNC (hs_4), .VGA_VSYNC (vs_4),
      .VGA_RED (r_4), .VGA_GREEN (g_4), .VGA_BLUE (b_4),
      .FRAME_TICK (tk_4)
   );

   vga_dither_out #(.OUT_W(8)) u_d0 (
      .CLK_25MHZ (clk), .RESET_N (rst_n), .DITHER_ON (don),
      .IN_HSYNC (ihs), .IN_VSYNC (ivs),
      .IN_RED (ir), .IN_GREEN (ig), .IN_BLUE (ib),
      .VGA_HSYNC (hs_0), .VGA_VSYNC (vs_0),
      .VGA_RED (r_0), .VGA_GREEN (g_0), .VGA_BLUE (b_0),
      .FRAME_TICK (tk_0)
   );

   vga_dither_out #(.OUT_W(6)) u_d2 (
      .CLK_25MHZ (clk), .RESET_N (rst_n), .DITHER_ON (don),
      .IN_HSYNC (ihs), .IN_VSYNC (ivs),
      .IN_RED (ir), .IN_GREEN (ig), .IN_BLUE (ib),
      .VGA_HSYNC (hs_2), .VGA_VSYNC (vs_2),
      .VGA_RED (r_2), .VGA_GREEN (g_2), .VGA_BLUE (b_2),
      .FRAME_TICK (tk_2)
   );

   typedef struct packed {
      logic           hs;
      logic           vs;
      logic           tick;
      logic [2:0][3:0] c4;
      logic [2:0][7:0] c0;
      logic [2:0][5:0] c2;
   } exp_t;

   exp_t q[$];
   exp_t em;
   bit   mon_en = 1'b0;
   int   n_chk  = 0;
   int   n_pass = 0;

   // reference position state, one step per driven pixel
   int mx = 0, my = 0, mf = 0;
   bit mact = 0, eh_p = 0, ev_p = 0, pha = 0, pva = 0;

   int bay[16] = '{0, 8, 2, 10, 12, 4, 14, 6,
                   3, 11, 1, 9, 15, 7, 13, 5};

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", nm, got, exp);
   endtask

   function automatic int exp_ch(int v, int d, int bxy, bit act);
      int t, s, lim;
      t = 0;
      if (act && d != 0)
         t = (d >= 4) ? (bxy << (d - 4)) : (bxy >> (4 - d));
      s   = (v + t) >> d;
      lim = (1 << (8 - d)) - 1;
      return (s > lim) ? lim : s;
   endfunction

   // Called at a negedge; drives one pixel, queues its expectation,
   // then waits for the following negedge.
   task automatic drive(input bit ha, input bit va,
                        input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input bit dn);
      exp_t e;
      int   bxy;
      int   c[3];
      ihs = ~ha; ivs = ~va;
      ir = r; ig = g; ib = b; don = dn;
      if (eh_p) begin mx = 0; my = (my + 1) % 4; end
      else mx = (mx + 1) % 4;
      if (ev_p) begin my = 0; mf = (mf + 1) % 4; mact = dn; end
      bxy = bay[((my + mf) % 4) * 4 + ((mx + mf) % 4)];
      c[0] = int'(r); c[1] = int'(g); c[2] = int'(b);
      e.hs   = ~ha;
      e.vs   = ~va;
      e.tick = va && !pva;
      for (int k = 0; k < 3; k++) begin
         e.c4[k] = 4'(exp_ch(c[k], 4, bxy, mact));
         e.c0[k] = 8'(exp_ch(c[k], 0, bxy, mact));
         e.c2[k] = 6'(exp_ch(c[k], 2, bxy, mact));
      end
      eh_p = ha && !pha;
      ev_p = va && !pva;
      pha = ha;
      pva = va;
      q.push_back(e);
      @(negedge clk);
   endtask

   // One VS line plus nl normal lines, 8 pixels each, HS on pixel 0.
   task automatic frame(input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input bit dn_vs,
                        input bit dn_rest, input int nl, input bit ramp);
      int p;
      p = 0;
      for (int l = 0; l <= nl; l++) begin
         for (int i = 0; i < 8; i++) begin
            if (ramp)
               drive(i == 0, l == 0, 8'(r + p * 37), 8'(g + p * 53),
                     8'(b + p * 11), (l == 0) ? dn_vs : dn_rest);
            else
               drive(i == 0, l == 0, r, g, b,
                     (l == 0) ? dn_vs : dn_rest);
            p++;
         end
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (mon_en && q.size() >= 2) begin
         em = q.pop_front();
         chk("d4", 64'({hs_4, vs_4, tk_4, b_4, g_4, r_4}),
             64'({em.hs, em.vs, em.tick, em.c4}));
         chk("d0", 64'({hs_0, vs_0, tk_0, b_0, g_0, r_0}),
             64'({em.hs, em.vs, em.tick, em.c0}));
         chk("d2", 64'({hs_2, vs_2, tk_2, b_2, g_2, r_2}),
             64'({em.hs, em.vs, em.tick, em.c2}));
      end
   end

   initial begin
      rst_n = 1'b0;
      don = 1'b0;
      ihs = 1'b1; ivs = 1'b1;
      ir = '0; ig = '0; ib = '0;
      repeat (5) begin
         @(negedge clk);
         ihs = 1'($urandom); ivs = 1'($urandom);
         ir = 8'($urandom); ig = 8'($urandom); ib = 8'($urandom);
         don = 1'($urandom);
         @(posedge clk);
         #1;
         chk("rst4", 64'({hs_4, vs_4, tk_4, b_4, g_4, r_4}),
             64'({3'b110, 12'h000}));
         chk("rst0", 64'({hs_0, vs_0, tk_0, b_0, g_0, r_0}),
             64'({3'b110, 24'h000000}));
         chk("rst2", 64'({hs_2, vs_2, tk_2, b_2, g_2, r_2}),
             64'({3'b110, 18'h00000}));
      end
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      frame(8'hA7, 8'hA7, 8'hA7, 1'b0, 1'b0, 3, 1'b0);
      frame(8'h08, 8'h08, 8'h08, 1'b1, 1'b1, 3, 1'b0);
      frame(8'h08, 8'h08, 8'h08, 1'b0, 1'b1, 3, 1'b0);
      frame(8'h08, 8'h08, 8'h08, 1'b1, 1'b1, 3, 1'b0);
      frame(8'h08, 8'h08, 8'h08, 1'b1, 1'b1, 3, 1'b0);
      frame(8'hFF, 8'h00, 8'h80, 1'b1, 1'b1, 3, 1'b0);
      frame(8'h01, 8'h01, 8'h01, 1'b1, 1'b1, 3, 1'b0);
      frame(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 3, 1'b0);
      frame(8'h10, 8'h90, 8'h3C, 1'b1, 1'b1, 3, 1'b1);
      frame(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 3, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);

      @(posedge clk);
      #2;
      chk("drain", 64'(q.size()), 64'd1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
